// File: rtl/text_row_sched_pkg.sv
// Shared constants and types for the text-row fill scheduler.
// Geometry, fill code and fill FSM state encoding.
package vga_text_pkg;
   localparam int HCHAR        = 48;
   localparam int VCHAR        = 18;
   localparam int BITPERCH     = 4;
   localparam int FONTVLENLOG2 = 5;
   localparam int VPR          = HCHAR / 3;
   localparam int SLOT_W       = 3 * BITPERCH;
   localparam int LINE_W       = BITPERCH * HCHAR;

   localparam logic [BITPERCH-1:0] FILL_CODE = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CONV,
      NEXT
   } fill_state_e;
endpackage

// File: rtl/text_row_sched_if.sv
// Sample RAM read port between the row scheduler and the RAM.
interface text_row_sched_if #(
   parameter int ADR_BITS = 6,
   parameter int N        = 10
);
   logic                rd_en;
   logic [ADR_BITS-1:0] rd_addr;
   logic [N-1:0]        rd_data;

   modport master (output rd_en, output rd_addr, input rd_data);
   modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/text_row_sched_bin2bcd3.sv
// 10-bit binary to three BCD digits, saturating at 999.
module bin2bcd3 (
   input  logic [9:0]  bin,
   output logic [11:0] bcd
);
   logic [9:0]  v;
   logic [21:0] sh;

   // shift-and-add-3 over the saturated value
   always_comb begin
      v  = (bin > 10'd999) ? 10'd999 : bin;
      sh = {12'd0, v};
      for (int i = 0; i < 10; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (sh[10+4*d +: 4] >= 4'd5) begin
               sh[10+4*d +: 4] = sh[10+4*d +: 4] + 4'd3;
            end
         end
         sh = sh << 1;
      end
      bcd = sh[21:10];
   end
endmodule

// File: rtl/text_row_sched.sv
// Row-fill scheduler: prefetches text row r+1 as BCD codes into a back
// buffer and swaps it to the front line buffer at each row boundary.
module text_row_sched
   import vga_text_pkg::*;
#(
   parameter int L        = 60,
   parameter int N        = 10,
   parameter int ADR_BITS = 6,
   parameter int RD_LAT   = 1,
   parameter int NPAGES   = 1
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [10:0]       vcnt,
   input  logic              page_next,
   text_row_sched_if.master  rd,
   output logic [LINE_W-1:0] lineout,
   output logic              fill_busy,
   output logic              row_ready,
   output logic              underrun,
   output logic [2:0]        page
);
   localparam int K_W    = $clog2(VPR);
   localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   fill_state_e       state_q, state_d;
   logic [4:0]        row_q, row_d;
   logic [4:0]        tgt_q, tgt_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [LINE_W-1:0] front_q, front_d;
   logic [LINE_W-1:0] back_q, back_d;
   logic              row_ready_q, row_ready_d;
   logic              underrun_q, underrun_d;
   logic              page_pend_q, page_pend_d;
   logic [2:0]        page_q, page_d;

   logic [4:0]        row;
   logic              row_ev, in_vis, last, done, oob;
   logic [15:0]       addr;
   logic [11:0]       bcd;
   int                slot_lo;
   logic              unused_vcnt;

   assign row         = vcnt[FONTVLENLOG2 +: 5];
   assign unused_vcnt = ^{vcnt[10], vcnt[FONTVLENLOG2-1:0]};
   assign row_ev      = (row != row_q);
   assign in_vis      = (row < 5'(VCHAR));
   assign last        = (k_q == K_W'(VPR - 1));
   assign done        = (state_q == NEXT) && last;
   assign addr        = 16'(page_q) * 16'(VCHAR * VPR)
                      + 16'(tgt_q) * 16'(VPR) + 16'(k_q);
   assign oob         = (addr >= 16'(L));
   assign slot_lo     = SLOT_W * (VPR - 1 - int'(k_q));

   bin2bcd3 u_bcd (
      .bin (10'(rd.rd_data)),
      .bcd (bcd)
   );

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= IDLE;
         row_q       <= 5'h1F;
         tgt_q       <= '0;
         k_q         <= '0;
         wcnt_q      <= '0;
         front_q     <= '1;
         back_q      <= '1;
         row_ready_q <= 1'b0;
         underrun_q  <= 1'b0;
         page_pend_q <= 1'b0;
         page_q      <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         tgt_q       <= tgt_d;
         k_q         <= k_d;
         wcnt_q      <= wcnt_d;
         front_q     <= front_d;
         back_q      <= back_d;
         row_ready_q <= row_ready_d;
         underrun_q  <= underrun_d;
         page_pend_q <= page_pend_d;
         page_q      <= page_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      wcnt_d  = wcnt_q;
      tgt_d   = tgt_q;
      row_d   = row;
      unique case (state_q)
         IDLE:  state_d = IDLE;
         ISSUE: begin
            wcnt_d  = '0;
            state_d = oob ? NEXT : ((RD_LAT > 1) ? WAIT : CONV);
         end
         WAIT: begin
            if (wcnt_q == WCNT_W'(RD_LAT - 2)) state_d = CONV;
            else wcnt_d = wcnt_q + 1'b1;
         end
         CONV:  state_d = NEXT;
         NEXT: begin
            if (last) begin
               state_d = IDLE;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a visible row boundary always restarts the prefetch
      if (row_ev && in_vis) begin
         state_d = ISSUE;
         k_d     = '0;
         tgt_d   = (row == 5'(VCHAR - 1)) ? 5'd0 : row + 5'd1;
      end
   end

   always_comb begin
      front_d     = front_q;
      back_d      = back_q;
      row_ready_d = row_ready_q | done;
      underrun_d  = 1'b0;
      page_d      = page_q;
      page_pend_d = page_pend_q | page_next;
      rd.rd_en    = 1'b0;
      rd.rd_addr  = '0;
      if (state_q == ISSUE && !oob) begin
         rd.rd_en   = 1'b1;
         rd.rd_addr = addr[ADR_BITS-1:0];
      end
      if (state_q == ISSUE && oob) back_d[slot_lo +: SLOT_W] = {3{FILL_CODE}};
      if (state_q == CONV) back_d[slot_lo +: SLOT_W] = bcd;
      // a fill finishing on the boundary cycle still counts as ready
      if (row_ev && in_vis) begin
         if (row_ready_q || done) front_d = back_q;
         row_ready_d = 1'b0;
         underrun_d  = (state_q != IDLE) && !done;
         if (row == 5'(VCHAR - 1) && page_pend_d) begin
            page_d      = (page_q == 3'(NPAGES - 1)) ? 3'd0 : page_q + 3'd1;
            page_pend_d = 1'b0;
         end
      end
   end

   assign lineout   = front_q;
   assign fill_busy = (state_q != IDLE);
   assign row_ready = row_ready_q;
   assign underrun  = underrun_q;
   assign page      = page_q;
endmodule

// File: tb/tb_text_row_sched.sv
// Self-checking bench for text_row_sched: three instances cover the
// nominal fill, a slow RAM (underrun) and two-page operation.
module tb_text_row_sched;
   logic clk = 1'b0;
   logic RST = 1'b1;
   logic [10:0] vcnt_a, vcnt_b, vcnt_c;
   logic pn_c = 1'b0;
   logic [191:0] line_a, line_b, line_c;
   logic busy_a, busy_b, busy_c, rr_a, rr_b, rr_c;
   logic und_a, und_b, und_c;
   logic [2:0] pg_a, pg_b, pg_c;
   logic [9:0] mem [64];
   logic [9:0] pipe_b [20];
   int total = 0, bad = 0;
   int ren_a = 0, ren_c = 0, ucnt_a = 0, ucnt_b = 0;
   logic [191:0] exp_next;

   always #5 clk = ~clk;

   text_row_sched_if #(.ADR_BITS(6), .N(10)) rif_a ();
   text_row_sched_if #(.ADR_BITS(6), .N(10)) rif_b ();
   text_row_sched_if #(.ADR_BITS(6), .N(10)) rif_c ();

   text_row_sched #(.RD_LAT(1), .NPAGES(1)) dut_a (
      .clk(clk), .RST(RST), .vcnt(vcnt_a), .page_next(1'b0),
      .rd(rif_a), .lineout(line_a), .fill_busy(busy_a),
      .row_ready(rr_a), .underrun(und_a), .page(pg_a));
   text_row_sched #(.RD_LAT(20), .NPAGES(1)) dut_b (
      .clk(clk), .RST(RST), .vcnt(vcnt_b), .page_next(1'b0),
      .rd(rif_b), .lineout(line_b), .fill_busy(busy_b),
      .row_ready(rr_b), .underrun(und_b), .page(pg_b));
   text_row_sched #(.RD_LAT(1), .NPAGES(2)) dut_c (
      .clk(clk), .RST(RST), .vcnt(vcnt_c), .page_next(pn_c),
      .rd(rif_c), .lineout(line_c), .fill_busy(busy_c),
      .row_ready(rr_c), .underrun(und_c), .page(pg_c));

   // RAM models: garbage unless a read was strobed RD_LAT cycles ago
   always @(posedge clk) begin
      rif_a.rd_data <= rif_a.rd_en ? mem[rif_a.rd_addr] : 10'h2AA;
      rif_c.rd_data <= rif_c.rd_en ? mem[rif_c.rd_addr] : 10'h2AA;
      pipe_b[0] <= rif_b.rd_en ? mem[rif_b.rd_addr] : 10'h2AA;
      for (int i = 1; i < 20; i++) pipe_b[i] <= pipe_b[i-1];
      if (rif_a.rd_en) ren_a <= ren_a + 1;
      if (rif_c.rd_en) ren_c <= ren_c + 1;
      if (und_a) ucnt_a <= ucnt_a + 1;
      if (und_b) ucnt_b <= ucnt_b + 1;
   end
   assign rif_b.rd_data = pipe_b[19];

   function automatic logic [191:0] exp_row(int pg, int t);
      logic [191:0] r;
      int a, v;
      r = '1;
      for (int k = 0; k < 16; k++) begin
         a = pg * 288 + t * 16 + k;
         if (a >= 60) begin
            r[191-12*k -: 12] = 12'hFFF;
         end else begin
            v = int'(mem[a]);
            if (v > 999) v = 999;
            r[191-12*k -: 12] = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         end
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [191:0] got,
                      input logic [191:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_mem();
      for (int k = 0; k < 64; k++) mem[k] = 10'($urandom_range(0, 1023));
      mem[5] = 10'd1023;
   endtask

   initial begin
      int base, u0;
      logic [191:0] cur;
      vcnt_a = 11'd0;
      vcnt_b = 11'(20 * 32);
      vcnt_c = 11'(20 * 32);
      for (int k = 0; k < 64; k++) mem[k] = 10'(k * 7);
      tick(3);
      chk("rst_line", line_a, '1);
      chk("rst_rr", rr_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_und", und_a, 0);
      chk("rst_ren", rif_a.rd_en, 0);
      chk("rst_radr", rif_a.rd_addr, 0);
      chk("rst_page", pg_a, 0);

      RST = 1'b0;
      tick(1);
      chk("row0_front", line_a, '1);
      chk("row0_busy", busy_a, 1);
      tick(47);
      chk("rr_early", rr_a, 0);
      tick(1);
      chk("rr_48", rr_a, 1);
      chk("busy_48", busy_a, 0);

      vcnt_a = 11'd32;
      tick(1);
      chk("swap_slot0", line_a[191:180], 12'h112);
      chk("swap_row1", line_a, exp_row(0, 1));
      chk("fill2_busy", busy_a, 1);
      tick(55);
      vcnt_a = 11'd64;
      tick(1);
      chk("swap_row2", line_a, exp_row(0, 2));
      base = ren_a;
      tick(55);
      chk("row3_rden", ren_a - base, 12);
      vcnt_a = 11'd96;
      tick(1);
      chk("swap_row3", line_a, exp_row(0, 3));
      tick(55);

      vcnt_a = 11'(20 * 32);
      tick(5);
      rand_mem();
      vcnt_a = 11'(17 * 32 + $urandom_range(0, 31));
      tick(1);
      exp_next = exp_row(0, 0);
      tick(59);
      for (int f = 0; f < 3; f++) begin
         for (int r = 0; r < 18; r++) begin
            vcnt_a = 11'(r * 32 + $urandom_range(0, 31));
            tick(1);
            chk("rnd_row", line_a, exp_next);
            if (r == 0) chk("sat999", line_a[131:120], 12'h999);
            cur = exp_next;
            exp_next = exp_row(0, (r == 17) ? 0 : r + 1);
            tick($urandom_range(20, 30));
            vcnt_a = 11'(r * 32 + $urandom_range(0, 31));
            tick($urandom_range(30, 40));
         end
         for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
            vcnt_a = 11'((18 + b) * 32 + $urandom_range(0, 31));
            tick(1);
            chk("blank_hold", line_a, cur);
            tick(20);
         end
         rand_mem();
      end
      chk("no_underrun_a", ucnt_a, 0);

      vcnt_b = 11'd0;
      tick(1);
      chk("b_busy", busy_b, 1);
      tick(100);
      u0 = ucnt_b;
      vcnt_b = 11'd32;
      tick(1);
      chk("b_und", und_b, 1);
      chk("b_front", line_b, '1);
      chk("b_ren", rif_b.rd_en, 1);
      chk("b_tgt", rif_b.rd_addr, 32);
      tick(1);
      chk("b_und_pulse", und_b, 0);
      tick(400);
      chk("b_und_cnt", ucnt_b - u0, 1);
      chk("b_rr", rr_b, 1);
      vcnt_b = 11'd64;
      tick(1);
      chk("b_row2", line_b, exp_row(0, 2));

      vcnt_c = 11'd0;
      tick(60);
      pn_c = 1'b1;
      tick(1);
      pn_c = 1'b0;
      vcnt_c = 11'(5 * 32);
      tick(1);
      chk("c_page_hold", pg_c, 0);
      tick(59);
      vcnt_c = 11'(17 * 32);
      tick(1);
      chk("c_page_adv", pg_c, 1);
      base = ren_c;
      tick(59);
      chk("c_p1_rden", ren_c - base, 0);
      chk("c_p1_rr", rr_c, 1);
      vcnt_c = 11'd0;
      tick(1);
      chk("c_p1_row0", line_c, exp_row(1, 0));
      chk("c_page_keep", pg_c, 1);
      tick(59);
      pn_c = 1'b1;
      tick(1);
      pn_c = 1'b0;
      vcnt_c = 11'(17 * 32);
      tick(1);
      chk("c_page_wrap", pg_c, 0);
      base = ren_c;
      tick(59);
      chk("c_p0_rden", ren_c - base, 16);
      vcnt_c = 11'd0;
      tick(1);
      chk("c_p0_row0", line_c, exp_row(0, 0));
      tick(59);
      pn_c = 1'b1;
      tick(1);
      pn_c = 1'b0;
      vcnt_c = 11'(17 * 32);
      vcnt_a = 11'(2 * 32);
      tick(10);

      RST = 1'b1;
      tick(1);
      chk("mr_line_a", line_a, '1);
      chk("mr_rr_a", rr_a, 0);
      chk("mr_busy_a", busy_a, 0);
      chk("mr_ren_a", rif_a.rd_en, 0);
      chk("mr_radr_a", rif_a.rd_addr, 0);
      chk("mr_page_c", pg_c, 0);
      chk("mr_busy_c", busy_c, 0);
      chk("mr_und_c", und_c, 0);
      chk("mr_rr_c", rr_c, 0);
      RST = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/text_row_sched.md
# text_row_sched

Row-fill scheduler for the character display. It sequences reads from the sample RAM (`L` words of `N` bits) and converts each word to three 4-bit decimal codes. Results are written into a double-buffered 192-bit line register, which the pixel/font stage consumes as `lineout`. It sits between the sync generator (`vcnt`), the sample RAM read port and the font lookup, and prefetches text row r+1 while row r is on screen.

## Interface
- `HCHAR`, 48: characters per text row.
- `VCHAR`, 18: visible text rows.
- `VPR`, 16: values per row (`HCHAR`/3).
- `L`, 60: number of sample words.
- `N`, 10: sample width.
- `ADR_BITS`, 6: RAM address width.
- `RD_LAT`, 1: RAM read latency in cycles, ≥1.
- `NPAGES`, 1: page count (ceil(`L`/(`VCHAR`·`VPR`))).
- `FONTVLENLOG2`, 5: log2 of font rows per text row.
- `clk` in 1: the single clock.
- `RST` in 1: reset, synchronous, active-high.
- `vcnt` in 11: vertical line counter from sync.
- `page_next` in 1: one-cycle request to advance the page.
- `rd_en` out 1: read strobe.
- `rd_addr` out `ADR_BITS`: read address.
- `rd_data` in `N`: read data, valid `RD_LAT` cycles after `rd_en`.
- `lineout` out 4·`HCHAR`: front line buffer. Value k occupies bits [191−12k -: 12], hundreds digit most significant.
- `fill_busy` out 1: fill in progress.
- `row_ready` out 1: back buffer holds a complete row.
- `underrun` out 1: one-cycle pulse when a row boundary hits an unfinished fill.
- `page` out 3: active page.

## Operation
- Row index is r = `vcnt`[`FONTVLENLOG2` +: 5]. A registered copy `row_q` resets to 5'h1F. A row event is r ≠ `row_q`, and `row_q` <= r every cycle.
- On a row event with r < `VCHAR`:
  - If `row_ready`: front <= back, and `row_ready` <= 0.
  - If a fill is active: abort it, pulse `underrun`, and leave the front unchanged.
  - Then start a fill of target t = (r+1 == `VCHAR`) ? 0 : r+1.
- On a row event with r ≥ `VCHAR` (vertical blank): no swap, no fill.
- Page handling:
  - `page_next` sets `page_pend`.
  - At the row event r = `VCHAR`−1, before the row-0 prefetch address is computed: if `page_pend`, page <= (page+1 == `NPAGES`) ? 0 : page+1, and `page_pend` is cleared.
  - Page therefore only changes between frames.
- FSM states:
  - IDLE → ISSUE on fill start, with k=0.
  - ISSUE: compute a = page·`VCHAR`·`VPR` + t·`VPR` + k in 16-bit arithmetic.
    - If a ≥ `L`: write code FFF to slot k, go to NEXT.
    - Otherwise: `rd_en`=1, `rd_addr`=a[`ADR_BITS`−1:0], go to WAIT.
  - WAIT: hold for `RD_LAT`−1 cycles (0 cycles when `RD_LAT`=1), then go to CONV.
  - CONV: capture `rd_data`, convert it, write to back slot k, go to NEXT.
  - NEXT: if k == `VPR`−1, set `row_ready`=1 and go to IDLE; otherwise k+1 and go to ISSUE.
- Conversion: binary to three BCD digits. Values > 999 saturate to 999.
- A row event arriving in the same cycle as the final write: the write completes and `row_ready` is set first, so the swap occurs and there is no underrun.
- Reset values:
  - `lineout` and back buffer all ones.
  - `row_ready`=0, `fill_busy`=0, `underrun`=0, `rd_en`=0, `rd_addr`=0, `page`=0, `page_pend`=0.
  - FSM in IDLE, `row_q`=1F.
  - Reset mid-fill discards the fill.

## Timing
- Swap: `lineout` changes on the first edge at which the new `vcnt` is sampled, i.e. 1 cycle after `vcnt` crosses a row boundary.
- Per in-range value: `RD_LAT`+2 cycles (ISSUE, WAIT/CONV, NEXT). Per out-of-range value: 2 cycles.
- Full-row fill with `RD_LAT`=1: 48 cycles.
- Each fill must complete within one text row (32 lines).
- `fill_busy` is high from the cycle after fill start until the cycle `row_ready` rises.
- `rd_en` is high for exactly one cycle per in-range value.

## Structure
- Package `vga_text_pkg` holds:
  - `HCHAR`, `VCHAR`, `BITPERCH`=4, `FONTVLENLOG2`;
  - the fill code 4'hF;
  - the FSM state enum {IDLE, ISSUE, WAIT, CONV, NEXT}.
- Sub-module `bin2bcd3`: combinational, 10-bit in, 12-bit BCD out, saturating at 999.

## Test plan
- Reset, then `vcnt`=0. RAM[k]=k·7:
  - Row event r=0: the front stays all-ones.
  - After 48 cycles `row_ready`=1 and the back slots hold row 1 values (RAM[16..31]); slot 0 = 0x112.
- Step `vcnt` to 32 → `lineout`[191:180]=0x112 one cycle later, and the fill of row 2 starts.
- Row 3 with `L`=60: addresses 48..59 are read and slots 12..15 = FFF. `rd_en` count is 12.
- RAM word 1023 → slot reads 0x999.
- Advance `vcnt` by 32 lines while a fill is mid-way (force `RD_LAT`=20) → `underrun` pulses once, the front is unchanged, and the new fill targets r+1.
- Pulse `page_next` mid-frame with `NPAGES`=2 → `page` changes only at the row event r=17, the row-0 prefetch reads base address 288 (all FFF), and `RST` asserted mid-fill returns every output to its reset value on the next edge.
